// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_deserializer
// Description : I2S (Philips format) receive front end. Samples SD/WS on the
//               rising edge of the bit clock, locks onto a left-channel frame
//               start, deserializes MSB-first slots and publishes left/right
//               pairs through a valid/ready handshake. Sticky overrun and
//               slot-length error flags feed the status register.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deserializer #(
  parameter int DATA_W = 24,  // bits kept per channel, MSB-aligned in the slot
  parameter int SLOT_W = 32   // expected bit clocks per channel slot
) (
  input  logic              i_tclk,
  input  logic              i_nrst,
  input  logic              i_enable,
  input  logic              i_ws,
  input  logic              i_sd,
  input  logic              i_ready,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  output logic              o_overrun,
  output logic              o_slot_err,
  output logic              o_sync
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Slot length is compared on 7 bits so a saturated counter (63) plus the
  // final bit (64) still fits without wrapping back onto a legal length.
  localparam logic [6:0] C_SLOT_W  = 7'(SLOT_W);
  localparam logic [5:0] C_CNT_MAX = 6'd63;

  // --------------------------------------------------------------------------
  // Receiver state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // disabled: pipeline flushed, published data retained
    ST_SYNC = 2'd1,   // waiting for WS 1->0 (right LSB) to find a frame start
    ST_RECV = 2'd2    // locked: deserializing slots
  } state_t;

  state_t              state_q,     state_d;
  logic                ws_q,        ws_d;
  logic [5:0]          cnt_q,       cnt_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic [DATA_W-1:0]   left_hold_q, left_hold_d;
  logic                left_ok_q,   left_ok_d;
  logic [DATA_W-1:0]   left_q,      left_d;
  logic [DATA_W-1:0]   right_q,     right_d;
  logic                valid_q,     valid_d;
  logic                overrun_q,   overrun_d;
  logic                slot_err_q,  slot_err_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_ws_edge;    // any WS transition: current slot ends
  logic                w_ws_fall;    // WS 1->0: right slot ends, left begins
  logic [6:0]          w_slot_len;   // bits in the slot ending on this edge
  logic [DATA_W-1:0]   w_bit_sel;    // one-hot target of the current bit
  logic [DATA_W-1:0]   w_shift_in;   // shift register with current bit merged
  logic [5:0]          w_cnt_inc;    // saturating bit counter increment

  assign w_ws_edge  = (i_ws != ws_q);
  assign w_ws_fall  = ws_q & ~i_ws;
  assign w_slot_len = {1'b0, cnt_q} + 7'd1;
  assign w_cnt_inc  = (cnt_q == C_CNT_MAX) ? C_CNT_MAX : (cnt_q + 6'd1);

  // Decode the bit counter into the MSB-first write position; counts at or
  // beyond DATA_W select nothing so trailing slot bits are simply dropped.
  always_comb begin
    w_bit_sel = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_bit_sel[i] = (int'(cnt_q) == (DATA_W - 1 - i));
    end
  end

  // Bits never written stay zero, which zero-pads short slots in the LSBs.
  assign w_shift_in = shift_q | (w_bit_sel & {DATA_W{i_sd}});

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  // Computes state transitions, slot assembly, pair publication, handshake
  // and sticky error flags for the next rising edge.
  always_comb begin
    state_d     = state_q;
    ws_d        = i_ws;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    slot_err_d  = slot_err_q;

    // Consumer takes the pair; a publish later in this block re-asserts valid.
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    // Clear first so that a set event on the same edge takes priority.
    if (i_clr_err) begin
      overrun_d  = 1'b0;
      slot_err_d = 1'b0;
    end

    if (!i_enable) begin
      // Disable from any state: flush the partial frame, keep published data.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      shift_d   = '0;
      left_ok_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d     = '0;
          shift_d   = '0;
          left_ok_d = 1'b0;
          valid_d   = 1'b0;
          state_d   = ST_SYNC;
        end

        ST_SYNC: begin
          // The bit sampled with the falling WS is a right LSB of unknown
          // history; drop it so the next bit starts a clean left slot.
          if (w_ws_fall) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = ST_RECV;
          end
        end

        ST_RECV: begin
          if (!w_ws_edge) begin
            shift_d = w_shift_in;
            cnt_d   = w_cnt_inc;
          end else begin
            // This bit is the LSB of the slot belonging to channel ws_q.
            cnt_d   = '0;
            shift_d = '0;
            if (w_slot_len != C_SLOT_W) begin
              slot_err_d = 1'b1;
            end
            if (!ws_q) begin
              left_hold_d = w_shift_in;
              left_ok_d   = 1'b1;
            end else if (left_ok_q) begin
              left_d    = left_hold_q;
              right_d   = w_shift_in;
              valid_d   = 1'b1;
              left_ok_d = 1'b0;
              // Overwriting an unaccepted pair loses data.
              if (valid_q && !i_ready) begin
                overrun_d = 1'b1;
              end
            end
            // A right slot without a preceding left slot is dropped.
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // All receiver flops; asynchronous active-low reset to the idle state.
  always_ff @(posedge i_tclk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      ws_q        <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      slot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      slot_err_q  <= slot_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_left     = left_q;
  assign o_right    = right_q;
  assign o_valid    = valid_q;
  assign o_overrun  = overrun_q;
  assign o_slot_err = slot_err_q;
  assign o_sync     = (state_q == ST_RECV);

endmodule
`default_nettype wire

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
- I2S receive front end; the counterpart of the transmit-side bit-clock/word-select path.
- Samples serial data (SD) and word select (WS) driven by a transmitter that changes them on the falling edge of i_tclk.
- Detects WS transitions, deserializes MSB-first Philips-format slots, and presents a left/right stereo pair to the APB side through a valid/ready handshake.
- Provides sticky overrun and slot-length error flags for the status register.

Parameters:
- DATA_W, 24, bits kept per channel; range 1..32; MSB-aligned within the slot.
- SLOT_W, 32, expected SCK cycles per channel slot; range 2..63; used only for the length check.

Ports:
- i_tclk, input, 1, serial bit clock; all logic on the rising edge.
- i_nrst, input, 1, reset, asynchronous, active-low.
- i_enable, input, 1, receive enable, synchronous to i_tclk.
- i_ws, input, 1, word select; 0 = left, 1 = right.
- i_sd, input, 1, serial data, MSB first.
- i_ready, input, 1, consumer accepts the pair when o_valid && i_ready.
- i_clr_err, input, 1, synchronous clear of o_overrun and o_slot_err.
- o_left, output, DATA_W, last complete left word.
- o_right, output, DATA_W, last complete right word.
- o_valid, output, 1, stereo pair available.
- o_overrun, output, 1, sticky: a pair was overwritten before acceptance.
- o_slot_err, output, 1, sticky: slot length != SLOT_W.
- o_sync, output, 1, high while in state RECV.

Behaviour:
- Reset: all outputs 0, state IDLE, ws_q=0, cnt=0, shift register=0, left_hold=0, left_ok=0.
- ws_q holds i_ws sampled on the previous rising edge. edge = i_ws != ws_q, evaluated each rising edge. ws_q updates every cycle regardless of state.
- Philips timing: WS changes one bit before the MSB. The bit sampled on the edge where a WS change is first seen is the LSB of the slot belonging to channel ws_q.
- State IDLE: entered whenever i_enable=0 (from any state, next edge). Clears cnt, shift register and left_ok, and forces o_valid=0. o_left/o_right, error flags and o_overrun retain their values. Leaves to SYNC when i_enable=1.
- State SYNC: waits for a falling WS edge (ws_q=1, i_ws=0), which marks the LSB of a right slot. On that edge it discards data, sets cnt=0 and moves to RECV. The first MSB captured is the left MSB on the next edge. Any partial frame before sync is never output.
- State RECV, no edge:
  - if cnt < DATA_W, write i_sd into shift bit [DATA_W-1-cnt];
  - cnt <= cnt+1, saturating at 63.
- State RECV, edge (slot end):
  - final bit written at index cnt if cnt < DATA_W;
  - slot length = cnt+1; if it differs from SLOT_W, set o_slot_err;
  - completed word = shift register including the final bit; bits beyond the received count stay 0 (short slots are zero-padded in the LSBs);
  - cnt <= 0 and shift register <= 0 for the next slot.
- Left slot complete (ws_q=0): left_hold <= word, left_ok <= 1.
- Right slot complete (ws_q=1):
  - if left_ok: o_left <= left_hold, o_right <= word, o_valid <= 1, left_ok <= 0;
  - if !left_ok: the word is dropped and no pair is published.
- Handshake:
  - o_valid falls on the edge after o_valid && i_ready, unless a new pair loads on that same edge; then o_valid stays 1 with the new data and no overrun.
  - Publish while o_valid=1 and i_ready=0: data is overwritten, o_valid stays 1, o_overrun <= 1.
  - o_left/o_right are stable while o_valid=1 and no new publish occurs.
- i_clr_err: clears both sticky flags. If a new set event occurs on the same edge, set wins.
- Latency: o_valid rises on the rising edge that samples the right-slot LSB, i.e. one cycle after WS falls for the next frame.
- Async reset mid-frame: immediate return to the reset state. After release, SYNC must see a fresh falling WS edge before data is accepted.

Test Plan:
- Sync and basic pair: enable, drive 32-bit slots, left=0xA5A5A5, right=0x3C3C3C (DATA_W=24, 8 trailing zero bits) -> o_valid one edge after the right LSB, o_left=0xA5A5A5, o_right=0x3C3C3C, o_slot_err=0, o_sync=1.
- Start mid-frame: enable while WS=0 mid-left slot -> no output until the first full left/right pair after a 1->0 WS edge; the first pair is correct and the partial slot is discarded.
- Backpressure: i_ready=0 across two frames with pairs (1,2) then (3,4) -> o_left=3, o_right=4, o_overrun=1. Then i_ready=1 for one cycle -> o_valid=0 next edge. i_clr_err -> o_overrun=0.
- Accept coincident with publish: i_ready=1 on the exact edge the next pair loads -> o_valid stays 1, new data present, o_overrun stays 0.
- Slot length: one left slot of 31 bits, MSB-first pattern 0xFFFFFF.. -> o_slot_err=1; the word is still output, bits beyond the received count are zero.
- Disable/reset mid-frame: deassert i_enable at bit 10 of the left slot -> o_valid=0, o_sync=0; re-enable -> resync on the next 1->0 WS edge. Pulse i_nrst mid-slot -> all outputs 0 immediately.
